// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester, single-outstanding memory arbiter.
//
// Requester 0 is instruction fetch and requester 1 is load/store. Only one
// transaction is in flight at a time. The FSM moves through IDLE, then ACCESS
// (LATENCY cycles), then RESP (until the owner takes the response).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req_valid/ready         request handshake, X = 0 (fetch), 1 (ld/st)
//   mX_addr/wen/wdata/len      request payload (byte address, write flag,
//                              write data, byte length)
//   mX_resp_valid/ready        response handshake
//   mX_rdata                   read data, or 0 when X does not own a response
//   ram_valid/wen              RAM read enable and write strobe
//   ram_addr/wdata/rlen        latched request fields presented to the RAM
//   ram_rdata                  combinational RAM read data
//   busy                       high whenever the FSM is outside IDLE
//   grant_id                   owner of the current or most recent transaction
module mem_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic [31:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_len,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic [31:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_len,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [31:0] m1_rdata,
  output logic        ram_valid,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [31:0] ram_rlen,
  input  logic [31:0] ram_rdata,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // The counter counts down to 0, so ACCESS lasts exactly LATENCY cycles.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state_reg;
  logic [3:0]  cnt_reg;
  logic        ptr_reg;      // requester granted last; the other one wins a tie
  logic        grant_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] len_reg;
  logic [31:0] rdata_reg;
  logic        wen_reg;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] rdata_out [2];

  logic is_idle;
  logic is_access;
  logic is_resp;
  logic any_req;
  logic winner;
  logic last_access;

  assign req_valid  = {m1_req_valid, m0_req_valid};
  assign resp_ready = {m1_resp_ready, m0_resp_ready};

  assign is_idle     = (state_reg == ST_IDLE);
  assign is_access   = (state_reg == ST_ACCESS);
  assign is_resp     = (state_reg == ST_RESP);
  assign any_req     = |req_valid;
  assign last_access = is_access && (cnt_reg == 4'd0);

  // A sole requester wins. On a tie, the requester that was not granted
  // last wins.
  assign winner = (req_valid == 2'b11) ? ~ptr_reg : req_valid[1];

  // Per-requester handshake and response outputs. The ready output is gated
  // by rst_n so that every output stays low while reset is held.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi]  = rst_n && is_idle && req_valid[gi] && (winner == 1'(gi));
    assign resp_valid[gi] = is_resp && (grant_reg == 1'(gi));
    assign rdata_out[gi]  = resp_valid[gi] ? rdata_reg : 32'h0;
  end

  assign m0_req_ready  = req_ready[0];
  assign m1_req_ready  = req_ready[1];
  assign m0_resp_valid = resp_valid[0];
  assign m1_resp_valid = resp_valid[1];
  assign m0_rdata      = rdata_out[0];
  assign m1_rdata      = rdata_out[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      ptr_reg   <= 1'b1;
      grant_reg <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      len_reg   <= 32'h0;
      rdata_reg <= 32'h0;
      wen_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // The winner's ready follows its own valid, so any pending request
          // is a handshake.
          if (any_req) begin
            grant_reg <= winner;
            addr_reg  <= winner ? m1_addr  : m0_addr;
            wen_reg   <= winner ? m1_wen   : m0_wen;
            wdata_reg <= winner ? m1_wdata : m0_wdata;
            len_reg   <= winner ? m1_len   : m0_len;
            cnt_reg   <= CNT_LOAD;
            state_reg <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_reg == 4'd0) begin
            rdata_reg <= wen_reg ? 32'h0 : ram_rdata;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready[grant_reg]) begin
            ptr_reg   <= grant_reg;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Writes with addr[28] set address an unmapped region. They are dropped
  // silently but still get a response.
  assign ram_valid = is_access;
  assign ram_wen   = last_access && wen_reg && !addr_reg[28];
  assign ram_addr  = addr_reg;
  assign ram_wdata = wdata_reg;
  assign ram_rlen  = len_reg;
  assign busy      = !is_idle;
  assign grant_id  = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Instance 0 uses LATENCY=1 and
// instance 1 uses LATENCY=3. Each instance has its own behavioural RAM.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready;
  logic [1:0]  m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready;
  logic [31:0] m0_addr [2], m0_wdata [2], m0_len [2], m0_rdata [2];
  logic [31:0] m1_addr [2], m1_wdata [2], m1_len [2], m1_rdata [2];
  logic [1:0]  ram_valid, ram_wen, busy, grant_id;
  logic [31:0] ram_addr [2], ram_wdata [2], ram_rlen [2], ram_rdata [2];

  logic [31:0] mem [2][64];
  int          wen_cnt [2];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          inst;
    int          req;
    logic [31:0] rdata;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int          inst;
    int          req;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] len;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [9];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(.LATENCY((gi == 0) ? 1 : 3)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .m0_req_valid (m0_req_valid[gi]),
      .m0_req_ready (m0_req_ready[gi]),
      .m0_addr      (m0_addr[gi]),
      .m0_wen       (m0_wen[gi]),
      .m0_wdata     (m0_wdata[gi]),
      .m0_len       (m0_len[gi]),
      .m0_resp_valid(m0_resp_valid[gi]),
      .m0_resp_ready(m0_resp_ready[gi]),
      .m0_rdata     (m0_rdata[gi]),
      .m1_req_valid (m1_req_valid[gi]),
      .m1_req_ready (m1_req_ready[gi]),
      .m1_addr      (m1_addr[gi]),
      .m1_wen       (m1_wen[gi]),
      .m1_wdata     (m1_wdata[gi]),
      .m1_len       (m1_len[gi]),
      .m1_resp_valid(m1_resp_valid[gi]),
      .m1_resp_ready(m1_resp_ready[gi]),
      .m1_rdata     (m1_rdata[gi]),
      .ram_valid    (ram_valid[gi]),
      .ram_wen      (ram_wen[gi]),
      .ram_addr     (ram_addr[gi]),
      .ram_wdata    (ram_wdata[gi]),
      .ram_rlen     (ram_rlen[gi]),
      .ram_rdata    (ram_rdata[gi]),
      .busy         (busy[gi]),
      .grant_id     (grant_id[gi])
    );
    assign ram_rdata[gi] = mem[gi][ram_addr[gi][7:2]];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_wen[k]) begin
        mem[k][ram_addr[k][7:2]] <= ram_wdata[k];
        wen_cnt[k] <= wen_cnt[k] + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input int i, input int r);
    return (r != 0) ? m1_req_ready[i] : m0_req_ready[i];
  endfunction

  function automatic logic get_resp(input int i, input int r);
    return (r != 0) ? m1_resp_valid[i] : m0_resp_valid[i];
  endfunction

  function automatic logic [31:0] get_rdata(input int i, input int r);
    return (r != 0) ? m1_rdata[i] : m0_rdata[i];
  endfunction

  task automatic drive_req(input int i, input int r, input logic v, input logic [31:0] a,
                           input logic w, input logic [31:0] wd, input logic [31:0] ln);
    if (r == 0) begin
      m0_req_valid[i] = v; m0_addr[i] = a; m0_wen[i] = w; m0_wdata[i] = wd; m0_len[i] = ln;
    end else begin
      m1_req_valid[i] = v; m1_addr[i] = a; m1_wen[i] = w; m1_wdata[i] = wd; m1_len[i] = ln;
    end
  endtask

  task automatic set_resp_ready(input int i, input int r, input logic v);
    if (r == 0) m0_resp_ready[i] = v;
    else        m1_resp_ready[i] = v;
  endtask

  // Single-requester transaction, started from a negedge.
  task automatic do_txn(input int i, input int r, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [31:0] ln, input logic [31:0] exp_rd);
    int   lat;
    int   base;
    logic wen_exp;
    logic got;
    sb_t  e;
    lat     = (i == 0) ? 1 : 3;
    wen_exp = w && !a[28];
    base    = wen_cnt[i];
    e.inst  = i;
    e.req   = r;
    e.rdata = exp_rd;
    sbq.push_back(e);
    drive_req(i, r, 1'b1, a, w, wd, ln);
    #1;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (get_ready(i, r)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    check("req_ready", 32'(got), 32'd1);
    if (!got) begin
      drive_req(i, r, 1'b0, a, w, wd, ln);
      void'(sbq.pop_back());
      return;
    end
    @(posedge clk); #1;
    drive_req(i, r, 1'b0, a, w, wd, ln);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check("access_ram_valid", 32'(ram_valid[i]), 32'd1);
      check("access_ram_wen", 32'(ram_wen[i]), 32'((k == lat) && wen_exp));
      check("access_resp_valid", 32'(get_resp(i, r)), 32'd0);
      if (k == 1) begin
        check("ram_addr", ram_addr[i], a);
        check("ram_rlen", ram_rlen[i], ln);
        check("ram_wdata", ram_wdata[i], wd);
        check("grant_id", 32'(grant_id[i]), 32'(r));
      end
    end
    @(negedge clk);
    check("resp_valid", 32'(get_resp(i, r)), 32'd1);
    check("other_resp_valid", 32'(get_resp(i, 1 - r)), 32'd0);
    check("other_rdata", get_rdata(i, 1 - r), 32'h0);
    check("resp_ram_valid", 32'(ram_valid[i]), 32'd0);
    e = sbq.pop_front();
    check("rdata", get_rdata(e.inst, e.req), e.rdata);
    check("wen_pulses", 32'(wen_cnt[i] - base), 32'(wen_exp));
    $display("txn inst=%0d m%0d %s addr=0x%08h len=%0d rdata=0x%08h",
             i, r, w ? "WR" : "RD", a, ln, get_rdata(i, r));
    set_resp_ready(i, r, 1'b1);
    @(posedge clk); #1;
    set_resp_ready(i, r, 1'b0);
    @(negedge clk);
    check("idle_busy", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1, 32'h0000_0008, 1'b1, 32'hDEAD_BEEF, 32'd4, 32'h0};
    vecs[1] = '{0, 0, 32'h0000_0008, 1'b0, 32'h0,         32'd4, 32'hDEAD_BEEF};
    vecs[2] = '{1, 1, 32'h0000_0004, 1'b1, 32'h1234_5678, 32'd4, 32'h0};
    vecs[3] = '{1, 0, 32'h0000_0004, 1'b0, 32'h0,         32'd4, 32'h1234_5678};
    vecs[4] = '{1, 1, 32'h1000_0004, 1'b1, 32'hAAAA_5555, 32'd4, 32'h0};
    vecs[5] = '{1, 1, 32'h0000_0004, 1'b0, 32'h0,         32'd4, 32'h1234_5678};
    vecs[6] = '{0, 0, 32'h0000_0009, 1'b0, 32'h0,         32'd2, 32'hDEAD_BEEF};
    vecs[7] = '{0, 1, 32'h0000_000C, 1'b1, 32'h0BAD_F00D, 32'd7, 32'h0};
    vecs[8] = '{0, 0, 32'h0000_000C, 1'b0, 32'h0,         32'd1, 32'h0BAD_F00D};

    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_req(k, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive_req(k, 1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      set_resp_ready(k, 0, 1'b0);
      set_resp_ready(k, 1, 1'b0);
    end

    // A request held during reset is not accepted, and every output reads 0.
    drive_req(0, 0, 1'b1, 32'h8, 1'b0, 32'h0, 32'd4);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(m0_req_ready[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_grant_id", 32'(grant_id[0]), 32'd0);
    check("rst_ram_valid", 32'(ram_valid[0]), 32'd0);
    check("rst_ram_addr", ram_addr[0], 32'h0);
    check("rst_resp_valid", 32'(m0_resp_valid[0]), 32'd0);
    check("rst_rdata", m0_rdata[0], 32'h0);

    // Arbitration happens in the first IDLE cycle after release. A request
    // dropped before its handshake leaves the FSM in IDLE.
    rst_n = 1'b1;
    #1;
    check("first_arb_ready", 32'(m0_req_ready[0]), 32'd1);
    drive_req(0, 0, 1'b0, 32'h8, 1'b0, 32'h0, 32'd4);
    @(negedge clk);
    check("drop_no_effect", 32'(busy[0]), 32'd0);

    // Both requesters tie twice: m0 wins first, then m1.
    drive_req(0, 0, 1'b1, 32'h0, 1'b0, 32'h0, 32'd4);
    drive_req(0, 1, 1'b1, 32'h8, 1'b0, 32'h0, 32'd4);
    #1;
    check("tie1_m0_ready", 32'(m0_req_ready[0]), 32'd1);
    check("tie1_m1_ready", 32'(m1_req_ready[0]), 32'd0);
    @(posedge clk); #1;
    drive_req(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd4);
    check("tie1_grant", 32'(grant_id[0]), 32'd0);
    check("tie1_m1_wait", 32'(m1_req_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    check("tie1_resp", 32'(m0_resp_valid[0]), 32'd1);
    set_resp_ready(0, 0, 1'b1);
    drive_req(0, 0, 1'b1, 32'h0, 1'b0, 32'h0, 32'd4);
    @(posedge clk); #1;
    set_resp_ready(0, 0, 1'b0);
    check("tie2_m1_ready", 32'(m1_req_ready[0]), 32'd1);
    check("tie2_m0_ready", 32'(m0_req_ready[0]), 32'd0);
    @(posedge clk); #1;
    drive_req(0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 32'd4);
    drive_req(0, 1, 1'b0, 32'h8, 1'b0, 32'h0, 32'd4);
    check("tie2_grant", 32'(grant_id[0]), 32'd1);
    repeat (2) @(negedge clk);
    check("tie2_resp", 32'(m1_resp_valid[0]), 32'd1);
    $display("txn inst=0 tie pair granted m0 then m1");
    set_resp_ready(0, 1, 1'b1);
    @(posedge clk); #1;
    set_resp_ready(0, 1, 1'b0);
    @(negedge clk);

    // Table-driven transactions.
    for (int v = 0; v < 9; v++) begin
      do_txn(vecs[v].inst, vecs[v].req, vecs[v].addr, vecs[v].wen,
             vecs[v].wdata, vecs[v].len, vecs[v].exp_rdata);
    end
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    // The response is held for 5 cycles. It stays stable, and a queued m0
    // request is not accepted.
    drive_req(0, 0, 1'b1, 32'h8, 1'b0, 32'h0, 32'd4);
    #1;
    check("hold_ready", 32'(m0_req_ready[0]), 32'd1);
    @(posedge clk); #1;
    drive_req(0, 0, 1'b1, 32'hC, 1'b0, 32'h0, 32'd4);
    @(negedge clk);
    check("hold_access_ready", 32'(m0_req_ready[0]), 32'd0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check("hold_resp_valid", 32'(m0_resp_valid[0]), 32'd1);
      check("hold_rdata", m0_rdata[0], 32'hDEAD_BEEF);
      check("hold_req_ready", 32'(m0_req_ready[0]), 32'd0);
      @(negedge clk);
    end
    check("hold_resp_valid_end", 32'(m0_resp_valid[0]), 32'd1);
    set_resp_ready(0, 0, 1'b1);
    @(posedge clk); #1;
    set_resp_ready(0, 0, 1'b0);
    check("after_resp_ready", 32'(m0_req_ready[0]), 32'd1);
    drive_req(0, 0, 1'b0, 32'hC, 1'b0, 32'h0, 32'd4);
    $display("txn inst=0 m0 RD addr=0x00000008 held response 5 cycles");
    @(negedge clk);
    check("after_hold_busy", 32'(busy[0]), 32'd0);

    // Reset during the ACCESS phase of a write: no write strobe and no
    // response afterwards.
    begin
      int base;
      base = wen_cnt[1];
      drive_req(1, 1, 1'b1, 32'h20, 1'b1, 32'hFFFF_0000, 32'd4);
      #1;
      check("rstacc_ready", 32'(m1_req_ready[1]), 32'd1);
      @(posedge clk); #1;
      drive_req(1, 1, 1'b0, 32'h20, 1'b1, 32'hFFFF_0000, 32'd4);
      @(negedge clk);
      check("rstacc_busy_before", 32'(busy[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstacc_busy", 32'(busy[1]), 32'd0);
      check("rstacc_ram_valid", 32'(ram_valid[1]), 32'd0);
      check("rstacc_ram_wen", 32'(ram_wen[1]), 32'd0);
      check("rstacc_grant", 32'(grant_id[1]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check("rstacc_no_resp", 32'(m1_resp_valid[1]), 32'd0);
        check("rstacc_idle", 32'(busy[1]), 32'd0);
      end
      check("rstacc_no_wen", 32'(wen_cnt[1] - base), 32'd0);
      $display("txn inst=1 m1 WR addr=0x00000020 discarded by reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
